addsub_pipe_nbit: RTL

Pipelined, parametrised N-bit adder/subtractor with a valid/ready stream interface and signed/unsigned flag modes. It splits the carry chain into SEG_W-bit segments, one segment per pipeline stage, to sustain one operation per cycle at N too wide for a single-cycle ripple chain. It feeds the wide arithmetic datapath, including the binary-to-BCD converter's correction and compare steps, and replaces the combinational adder/subtractor wherever operands arrive as a stream.

---
 rtl/addsub_pipe_nbit_pkg.sv | 43 ++++
 rtl/addsub_pipe_nbit_if.sv | 26 ++
 rtl/addsub_pipe_nbit_segment.sv | 26 ++
 rtl/addsub_pipe_nbit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/addsub_pipe_nbit_pkg.sv
// Shared arithmetic definitions: pipeline depth, per-stage control record and
// flag derivation used by the segmented adder/subtractor.
package addsub_pipe_nbit_pkg;

  // Number of carry-chain segments, one per pipeline stage.
  function automatic int calc_stages(input int n, input int seg_w);
    return n / seg_w;
  endfunction

  // Per-beat control travelling with each stage register. The width-dependent
  // parts (partial sum, skewed operands) sit beside it in the top as vectors
  // sized per stage, so only width-independent fields live here.
  typedef struct packed {
    logic vld;
    logic carry;
    logic add_n;
    logic signed_mode;
    logic xa_msb;
    logic yb_msb;
  } stage_ctrl_t;

  typedef struct packed {
    logic overflow;
    logic negative;
  } flags_t;

  // Range and sign flags from the operand MSBs (yb after inversion), the
  // result MSB and the carry out of the top bit.
  function automatic flags_t calc_flags(input logic xa_msb, input logic yb_msb,
                                        input logic s_msb, input logic c_out,
                                        input logic add_n, input logic signed_mode);
    flags_t f;
    if (signed_mode) begin
      f.overflow = (xa_msb == yb_msb) && (s_msb != xa_msb);
      f.negative = s_msb ^ f.overflow;
    end else begin
      f.overflow = add_n ? ~c_out : c_out;
      f.negative = add_n & ~c_out;
    end
    return f;
  endfunction

endpackage

// File: rtl/addsub_pipe_nbit_if.sv
// Operand/result stream bundle for the pipelined adder/subtractor.
interface addsub_pipe_nbit_if #(parameter int N = 16);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         add_n;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;
  logic         overflow;
  logic         negative;
  logic         zero;

  modport master (
    output in_valid, x, y, add_n, signed_mode, out_ready,
    input  in_ready, out_valid, s, c_out, overflow, negative, zero
  );

  modport slave (
    input  in_valid, x, y, add_n, signed_mode, out_ready,
    output in_ready, out_valid, s, c_out, overflow, negative, zero
  );
endinterface

// File: rtl/addsub_pipe_nbit_segment.sv
// Combinational SEG_W-bit ripple-carry adder slice.
module addsub_pipe_nbit_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             c_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             c_o
);

  logic [SEG_W:0] carry;

  // Ripple the carry bit by bit through the slice
  always_comb begin
    carry[0] = c_i;
    sum_o    = '0;
    for (int i = 0; i < SEG_W; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = carry[SEG_W];

endmodule

// File: rtl/addsub_pipe_nbit.sv
// Pipelined N-bit adder/subtractor: one SEG_W-bit carry segment per stage,
// valid/ready stream in and out, signed/unsigned flags on the final stage.
module addsub_pipe_nbit
  import addsub_pipe_nbit_pkg::*;
#(
  parameter int N     = 16,
  parameter int SEG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  addsub_pipe_nbit_if.slave  bus
);

  localparam int STAGES = calc_stages(N, SEG_W);

  if (SEG_W < 1 || (N % SEG_W) != 0) begin : g_param_chk
    $error("addsub_pipe_nbit: N must be a multiple of SEG_W and SEG_W must be >= 1");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int W_SRC = N - k * SEG_W;   // operand bits not yet consumed
    localparam int W_REM = W_SRC - SEG_W;   // bits still to skew past this stage
    localparam int W_S   = (k + 1) * SEG_W; // result bits produced so far

    stage_ctrl_t      src_ctrl;
    stage_ctrl_t      ctrl_d, ctrl_q;
    logic [W_SRC-1:0] src_xa, src_yb;
    logic [W_S-1:0]   s_new, s_d, s_q;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_c;
    logic             ld;

    // ---- stage boundary: source of segment k ----
    if (k == 0) begin : g_src
      assign src_xa   = bus.x;
      assign src_yb   = bus.add_n ? ~bus.y : bus.y;
      assign src_ctrl = '{vld: bus.in_valid, carry: bus.add_n, add_n: bus.add_n,
                          signed_mode: bus.signed_mode, xa_msb: bus.x[N-1],
                          yb_msb: src_yb[W_SRC-1]};
      assign s_new    = seg_sum;
    end else begin : g_src
      assign src_xa   = g_stage[k-1].g_skew.xa_q;
      assign src_yb   = g_stage[k-1].g_skew.yb_q;
      assign src_ctrl = g_stage[k-1].ctrl_q;
      assign s_new    = {seg_sum, g_stage[k-1].s_q};
    end

    // A stage may load when it is empty or its contents move on this cycle.
    if (k == STAGES - 1) begin : g_ld
      assign ld = ~ctrl_q.vld | bus.out_ready;
    end else begin : g_ld
      assign ld = ~ctrl_q.vld | g_stage[k+1].ld;
    end

    addsub_pipe_nbit_segment #(.SEG_W(SEG_W)) u_seg (
      .a_i   (src_xa[SEG_W-1:0]),
      .b_i   (src_yb[SEG_W-1:0]),
      .c_i   (src_ctrl.carry),
      .sum_o (seg_sum),
      .c_o   (seg_c)
    );

    // Take the next beat (or a bubble) when free; otherwise hold
    always_comb begin
      ctrl_d = ctrl_q;
      s_d    = s_q;
      if (ld) begin
        ctrl_d.vld = src_ctrl.vld;
        if (src_ctrl.vld) begin
          ctrl_d       = src_ctrl;
          ctrl_d.carry = seg_c;
          s_d          = s_new;
        end
      end
    end

    // Stage register: control and partial result
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ctrl_q <= '0;
        s_q    <= '0;
      end else begin
        ctrl_q <= ctrl_d;
        s_q    <= s_d;
      end
    end

    if (W_REM > 0) begin : g_skew
      logic [W_REM-1:0] xa_q, yb_q;

      // Carry the untouched upper operand segments forward with the beat
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          xa_q <= '0;
          yb_q <= '0;
        end else if (ld && src_ctrl.vld) begin
          xa_q <= src_xa[W_SRC-1:SEG_W];
          yb_q <= src_yb[W_SRC-1:SEG_W];
        end
      end
    end
  end

  // ---- stage boundary: final result and flags ----
  stage_ctrl_t  last_ctrl;
  logic [N-1:0] last_s;
  flags_t       flags;

  assign last_ctrl = g_stage[STAGES-1].ctrl_q;
  assign last_s    = g_stage[STAGES-1].s_q;
  assign flags     = calc_flags(last_ctrl.xa_msb, last_ctrl.yb_msb, last_s[N-1],
                                last_ctrl.carry, last_ctrl.add_n, last_ctrl.signed_mode);

  // Not ready while reset is asserted, even though every stage reads empty.
  assign bus.in_ready  = g_stage[0].ld & reset_n;
  assign bus.out_valid = last_ctrl.vld;
  assign bus.s         = last_s;
  assign bus.c_out     = last_ctrl.carry;
  assign bus.overflow  = flags.overflow;
  assign bus.negative  = flags.negative;
  assign bus.zero      = ~|last_s;

endmodule
